// File: rtl/operand_skid_stage.sv
// operand_skid_stage
//   Decode-to-execute skid stage. Buffers up to DEPTH uops in a small FIFO while
//   execute stalls. Register operands are read as a uop moves into the output
//   register. Same-cycle writebacks are forwarded, and the held operands are
//   refreshed while the output is stalled.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   flush                            drop every buffered and output uop
//   u_valid/u_stall/u_payload/u_rs*  upstream uop handshake and fields
//   d_valid/d_stall/d_payload/d_rs*  downstream uop handshake and fields
//   d_rs1_val, d_rs2_val             resolved source operands of the output uop
//   rf_raddr*/rf_rdata*              combinational register-file read port
//   wb_en/wb_rd/wb_data              writeback bus, used for forwarding
module operand_skid_stage #(
    parameter int PAYLOAD_W  = 32,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  u_valid,
    output logic                  u_stall,
    input  logic [PAYLOAD_W-1:0]  u_payload,
    input  logic [REG_ADDR_W-1:0] u_rs1,
    input  logic [REG_ADDR_W-1:0] u_rs2,
    output logic                  d_valid,
    input  logic                  d_stall,
    output logic [PAYLOAD_W-1:0]  d_payload,
    output logic [REG_ADDR_W-1:0] d_rs1,
    output logic [REG_ADDR_W-1:0] d_rs2,
    output logic [XLEN-1:0]       d_rs1_val,
    output logic [XLEN-1:0]       d_rs2_val,
    output logic [REG_ADDR_W-1:0] rf_raddr0,
    output logic [REG_ADDR_W-1:0] rf_raddr1,
    input  logic [XLEN-1:0]       rf_rdata0,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PAYLOAD_W-1:0]  fifoPayload [DEPTH];
    logic [REG_ADDR_W-1:0] fifoRs1     [DEPTH];
    logic [REG_ADDR_W-1:0] fifoRs2     [DEPTH];
    logic [PTR_W-1:0]      headPtr;
    logic [PTR_W-1:0]      tailPtr;
    logic [CNT_W-1:0]      count;

    logic                  fifoNonEmpty;
    logic                  ld;
    logic                  accept;
    logic                  pop;
    logic                  bypass;
    logic                  push;
    logic [PAYLOAD_W-1:0]  selPayload;
    logic [REG_ADDR_W-1:0] selRs1;
    logic [REG_ADDR_W-1:0] selRs2;
    logic [XLEN-1:0]       rs1Operand;
    logic [XLEN-1:0]       rs2Operand;
    logic                  refreshRs1;
    logic                  refreshRs2;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Stall depends only on the registered count, so neither u_valid nor
    // d_stall has a combinational path to it.
    assign u_stall = (count == CNT_W'(DEPTH));

    always_comb begin
        fifoNonEmpty = (count != '0);
        ld           = !d_valid || !d_stall;
        accept       = u_valid && !u_stall;
        pop          = ld && fifoNonEmpty;
        // An accepted uop bypasses the FIFO only when nothing older is waiting.
        bypass       = ld && !fifoNonEmpty && accept;
        push         = accept && !bypass;

        selPayload   = fifoNonEmpty ? fifoPayload[headPtr] : u_payload;
        selRs1       = fifoNonEmpty ? fifoRs1[headPtr]     : u_rs1;
        selRs2       = fifoNonEmpty ? fifoRs2[headPtr]     : u_rs2;

        if (ZERO_REG && selRs1 == '0)          rs1Operand = '0;
        else if (wb_en && wb_rd == selRs1)     rs1Operand = wb_data;
        else                                   rs1Operand = rf_rdata0;

        if (ZERO_REG && selRs2 == '0)          rs2Operand = '0;
        else if (wb_en && wb_rd == selRs2)     rs2Operand = wb_data;
        else                                   rs2Operand = rf_rdata1;

        refreshRs1   = wb_en && (wb_rd == d_rs1) && !(ZERO_REG && d_rs1 == '0);
        refreshRs2   = wb_en && (wb_rd == d_rs2) && !(ZERO_REG && d_rs2 == '0);
    end

    assign rf_raddr0 = selRs1;
    assign rf_raddr1 = selRs2;

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoPayload[tailPtr] <= u_payload;
            fifoRs1[tailPtr]     <= u_rs1;
            fifoRs2[tailPtr]     <= u_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
            d_valid   <= 1'b0;
            d_payload <= '0;
            d_rs1     <= '0;
            d_rs2     <= '0;
            d_rs1_val <= '0;
            d_rs2_val <= '0;
        end else if (flush) begin
            // Output data registers are left as-is; only validity is dropped.
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            d_valid <= 1'b0;
        end else begin
            if (ld) begin
                if (pop || bypass) begin
                    d_valid   <= 1'b1;
                    d_payload <= selPayload;
                    d_rs1     <= selRs1;
                    d_rs2     <= selRs2;
                    d_rs1_val <= rs1Operand;
                    d_rs2_val <= rs2Operand;
                end else begin
                    d_valid <= 1'b0;
                end
            end else begin
                // Held uop: keep operands in step with writebacks that land on it.
                if (refreshRs1) d_rs1_val <= wb_data;
                if (refreshRs2) d_rs2_val <= wb_data;
            end

            if (pop)  headPtr <= nextPtr(headPtr);
            if (push) tailPtr <= nextPtr(tailPtr);

            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_skid_stage.sv
// tb_operand_skid_stage
//   Drives operand_skid_stage with directed and random traffic. The reference is
//   an ordered list of every uop that is accepted and not yet consumed, plus the
//   register file contents. While valid, the output must show the oldest listed
//   uop, and its operands must equal the current register file values.
module tb_operand_skid_stage;

    localparam int PW    = 32;
    localparam int XL    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic [PW-1:0] pay;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
    } uop_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          u_valid = 1'b0;
    logic          u_stall;
    logic [PW-1:0] u_payload = '0;
    logic [AW-1:0] u_rs1 = '0;
    logic [AW-1:0] u_rs2 = '0;
    logic          d_valid;
    logic          d_stall = 1'b0;
    logic [PW-1:0] d_payload;
    logic [AW-1:0] d_rs1;
    logic [AW-1:0] d_rs2;
    logic [XL-1:0] d_rs1_val;
    logic [XL-1:0] d_rs2_val;
    logic [AW-1:0] rf_raddr0;
    logic [AW-1:0] rf_raddr1;
    logic [XL-1:0] rf_rdata0;
    logic [XL-1:0] rf_rdata1;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [XL-1:0] wb_data = '0;

    logic [XL-1:0] rfArr [32];
    uop_t          q[$];
    int            vectors = 0;
    int            miscompares = 0;

    assign rf_rdata0 = rfArr[rf_raddr0];
    assign rf_rdata1 = rfArr[rf_raddr1];

    always #5 clk = ~clk;

    operand_skid_stage #(
        .PAYLOAD_W(PW), .XLEN(XL), .REG_ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .u_valid(u_valid), .u_stall(u_stall), .u_payload(u_payload),
        .u_rs1(u_rs1), .u_rs2(u_rs2),
        .d_valid(d_valid), .d_stall(d_stall), .d_payload(d_payload),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XL-1:0] archVal(input logic [AW-1:0] r);
        return (r == '0) ? '0 : rfArr[r];
    endfunction

    task automatic checkAll();
        chk("d_valid", 64'(d_valid), 64'(q.size() > 0));
        chk("u_stall", 64'(u_stall), 64'(q.size() == DEPTH + 1));
        if (q.size() > 0) begin
            chk("d_payload", 64'(d_payload), 64'(q[0].pay));
            chk("d_rs1", 64'(d_rs1), 64'(q[0].r1));
            chk("d_rs2", 64'(d_rs2), 64'(q[0].r2));
            chk("d_rs1_val", 64'(d_rs1_val), 64'(archVal(q[0].r1)));
            chk("d_rs2_val", 64'(d_rs2_val), 64'(archVal(q[0].r2)));
        end
    endtask

    // One clock cycle: drive inputs, advance the reference, then check at negedge.
    task automatic step(input bit iRst, input bit iFlush, input bit iUv,
                        input logic [PW-1:0] iPay, input logic [AW-1:0] iR1,
                        input logic [AW-1:0] iR2, input bit iDs, input bit iWbEn,
                        input logic [AW-1:0] iWbRd, input logic [XL-1:0] iWbData);
        bit   acc;
        uop_t u;
        rst = iRst; flush = iFlush; u_valid = iUv; u_payload = iPay;
        u_rs1 = iR1; u_rs2 = iR2; d_stall = iDs;
        wb_en = iWbEn; wb_rd = iWbRd; wb_data = iWbData;
        #1;
        if (iRst || iFlush) begin
            q.delete();
        end else begin
            acc = iUv && (q.size() != DEPTH + 1);
            if (q.size() > 0 && !iDs) void'(q.pop_front());
            if (acc) begin
                u.pay = iPay; u.r1 = iR1; u.r2 = iR2;
                q.push_back(u);
            end
        end
        @(posedge clk);
        #1;
        if (iWbEn) rfArr[iWbRd] = iWbData;
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle(input bit iDs);
        step(0, 0, 0, '0, '0, '0, iDs, 0, '0, '0);
    endtask

    initial begin
        int seen;
        int stallSeen;
        int stallPct;
        for (int i = 0; i < 32; i++) rfArr[i] = 32'h1000 + 32'(i);
        rfArr[0] = 32'hDEAD_BEEF;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, '0, '0, '0, 0, 0, '0, '0);
        chk("rst_payload", 64'(d_payload), 64'h0);
        chk("rst_rs1_val", 64'(d_rs1_val), 64'h0);

        // Basic load with register reads
        rfArr[3] = 32'h11; rfArr[4] = 32'h22;
        step(0, 0, 1, 32'hCAFE_0001, 5'd3, 5'd4, 0, 0, '0, '0);
        chk("t1_valid", 64'(d_valid), 64'h1);
        chk("t1_rs1", 64'(d_rs1_val), 64'h11);
        chk("t1_rs2", 64'(d_rs2_val), 64'h22);

        // Writeback forwarded in the load cycle; rs2=0 reads zero
        step(0, 0, 1, 32'hCAFE_0002, 5'd3, 5'd0, 0, 1, 5'd3, 32'hAA);
        chk("t3_fwd", 64'(d_rs1_val), 64'hAA);
        chk("t3_zero", 64'(d_rs2_val), 64'h0);

        // Held operand refreshed by a writeback while stalled
        step(0, 0, 1, 32'hCAFE_0003, 5'd1, 5'd7, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, '0, 1, 1, 5'd7, 32'h55);
        chk("t4_refresh", 64'(d_rs2_val), 64'h55);
        idle(0); idle(0);

        // Stall with four offers: two buffered behind the output, fourth refused
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 32'hB000_0000 + 32'(i), 5'(i + 1), 5'(i + 2), 1, 0, '0, '0);
        chk("t2_full", 64'(u_stall), 64'h1);
        chk("t2_held", 64'(d_payload), 64'hB000_0000);
        for (int i = 0; i < 4; i++) idle(0);

        // Flush with a full FIFO, a valid output and a new offer
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 32'hF000_0000 + 32'(i), 5'd2, 5'd5, 1, 0, '0, '0);
        step(0, 1, 1, 32'hF000_00FF, 5'd2, 5'd5, 1, 0, '0, '0);
        chk("t5_valid", 64'(d_valid), 64'h0);
        chk("t5_stall", 64'(u_stall), 64'h0);
        for (int i = 0; i < 3; i++) idle(0);

        // Full throughput
        seen = 0; stallSeen = 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1, 32'hD000_0000 + 32'(i), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 0, 0, '0, '0);
            if (d_valid) seen++;
            if (u_stall) stallSeen++;
        end
        chk("t6_out", 64'(seen), 64'd100);
        chk("t6_stall", 64'(stallSeen), 64'd0);

        // Random traffic with varying stall pressure and frequent writebacks
        for (int i = 0; i < 3000; i++) begin
            stallPct = ((i / 200) % 2 == 0) ? 20 : 70;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) < 75), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < stallPct), ($urandom_range(0, 99) < 50),
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
